// File: rtl/cond_flag_unit_if.sv
// Bus between the instruction decoder and the conditional-execution stage.
// The decoder drives the instruction, its ungated write enables and the ALU flags;
// the stage returns the gated enables, the condition result, flags and counters.
interface cond_flag_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             inst_valid;
    logic [31:0]      inst;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       alu_flags;
    logic             RegWriteG;
    logic             MemWriteG;
    logic             cond_ex;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    modport master (
        output inst_valid, inst, RegWrite, MemWrite, alu_flags,
        input  RegWriteG, MemWriteG, cond_ex, flags, exec_count, skip_count
    );

    modport slave (
        input  inst_valid, inst, RegWrite, MemWrite, alu_flags,
        output RegWriteG, MemWriteG, cond_ex, flags, exec_count, skip_count
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: holds NZCV, evaluates inst[31:28] against it,
// gates the decoder's write enables and keeps saturating executed/skipped counters.
module cond_flag_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            reset,
    cond_flag_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] cnt_max = {CNT_W{1'b1}};

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;
    logic             n, z, c, v;
    logic             base;
    logic             pass;
    logic             flag_upd;

    assign {n, z, c, v} = flags_q;

    // Conditions come in complementary pairs: inst[31:29] picks the base test and
    // inst[28] inverts it. The 111 pair yields AL for 1110 and never for 1111.
    always_comb begin
        base = 1'b0;
        unique case (bus.inst[31:29])
            3'b000: base = z;
            3'b001: base = c;
            3'b010: base = n;
            3'b011: base = v;
            3'b100: base = c & ~z;
            3'b101: base = (n == v);
            3'b110: base = ~z & (n == v);
            3'b111: base = 1'b1;
        endcase
        pass = base ^ bus.inst[28];
    end

    // Data-processing ops update flags on CMP or when the S bit is set.
    assign flag_upd = bus.inst_valid & pass & (bus.inst[27:26] == 2'b00) &
                      ((bus.inst[24:21] == 4'b1010) | bus.inst[20]);

    assign bus.cond_ex    = pass & ~reset;
    assign bus.RegWriteG  = bus.RegWrite & bus.cond_ex & bus.inst_valid;
    assign bus.MemWriteG  = bus.MemWrite & bus.cond_ex & bus.inst_valid;
    assign bus.flags      = flags_q;
    assign bus.exec_count = exec_q;
    assign bus.skip_count = skip_q;

    // Flag register and saturating counters; bubbles leave everything untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            exec_q  <= '0;
            skip_q  <= '0;
        end else if (bus.inst_valid) begin
            if (flag_upd) begin
                flags_q <= bus.alu_flags;
            end
            if (pass) begin
                if (exec_q != cnt_max) exec_q <= exec_q + 1'b1;
            end else begin
                if (skip_q != cnt_max) skip_q <= skip_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit with a narrow counter width so that
// saturation is reachable; a behavioural model tracks flags and counts.
module tb_cond_flag_unit;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    cond_flag_unit_if #(.CNT_W(CW)) bus ();

    cond_flag_unit #(.CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_flags;
    int         m_exec;
    int         m_skip;

    // Flat condition table, N Z C V order.
    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit fn = f[3];
        bit fz = f[2];
        bit fc = f[1];
        bit fv = f[0];
        case (cc)
            4'd0:    return fz;
            4'd1:    return !fz;
            4'd2:    return fc;
            4'd3:    return !fc;
            4'd4:    return fn;
            4'd5:    return !fn;
            4'd6:    return fv;
            4'd7:    return !fv;
            4'd8:    return fc && !fz;
            4'd9:    return !fc || fz;
            4'd10:   return fn == fv;
            4'd11:   return fn != fv;
            4'd12:   return !fz && (fn == fv);
            4'd13:   return fz || (fn != fv);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_cond();
        return !reset && ref_cond(bus.inst[31:28], m_flags);
    endfunction

    // Sets inputs just after a falling edge and lets the combinational path settle.
    task automatic apply(input bit r, input bit vld, input logic [31:0] in, input bit rw,
                         input bit mw, input logic [3:0] af);
        reset          = r;
        bus.inst_valid = vld;
        bus.inst       = in;
        bus.RegWrite   = rw;
        bus.MemWrite   = mw;
        bus.alu_flags  = af;
        #1;
    endtask

    // Advances one clock, updating the model at the rising edge.
    task automatic clk_cycle();
        bit pass;
        bit is_dp;
        bit sets;
        @(posedge clk);
        if (reset) begin
            m_flags = 4'b0000;
            m_exec  = 0;
            m_skip  = 0;
        end else if (bus.inst_valid) begin
            pass  = ref_cond(bus.inst[31:28], m_flags);
            is_dp = (bus.inst[27:26] == 2'b00);
            sets  = (bus.inst[24:21] == 4'b1010) || bus.inst[20];
            if (pass) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
            else      m_skip = (m_skip < CMAX) ? m_skip + 1 : CMAX;
            if (pass && is_dp && sets) m_flags = bus.alu_flags;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 32'hE081_0002, 1, 1, 4'hF);
        if (bus.RegWriteG !== 1'b0) begin
            $display("FAIL reset_rwg: got %b want 0", bus.RegWriteG); n_err++;
        end
        n_vec++;
        if (bus.cond_ex !== 1'b0) begin
            $display("FAIL reset_cond: got %b want 0", bus.cond_ex); n_err++;
        end
        n_vec++;
        clk_cycle();
        apply(1, 1, 32'hE081_0002, 1, 1, 4'hF);
        clk_cycle();
        if (bus.flags !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", bus.flags); n_err++;
        end
        n_vec++;
        if (bus.exec_count !== '0 || bus.skip_count !== '0) begin
            $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.exec_count, bus.skip_count);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_cmp_then_cond();
        apply(0, 1, 32'hE150_0001, 0, 0, 4'b0100);
        clk_cycle();
        if (bus.flags !== 4'b0100) begin
            $display("FAIL cmp_flags: got %b want 0100", bus.flags); n_err++;
        end
        n_vec++;
        apply(0, 1, 32'h0081_0002, 1, 0, 4'b1011);
        if (bus.RegWriteG !== 1'b1) begin
            $display("FAIL addeq_rwg: got %b want 1", bus.RegWriteG); n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.exec_count !== CW'(2) || bus.flags !== 4'b0100) begin
            $display("FAIL addeq_state: got exec %0d flags %b want 2 0100",
                     bus.exec_count, bus.flags);
            n_err++;
        end
        n_vec++;
        apply(0, 1, 32'h1081_0002, 1, 0, 4'b0000);
        if (bus.RegWriteG !== 1'b0) begin
            $display("FAIL addne_rwg: got %b want 0", bus.RegWriteG); n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.skip_count !== CW'(1)) begin
            $display("FAIL addne_skip: got %0d want 1", bus.skip_count); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_cond_sweep();
        bit vld;
        bit rw;
        bit mw;
        for (int f = 0; f < 16; f++) begin
            apply(0, 1, 32'hE150_0001, 0, 0, 4'(f));
            clk_cycle();
            if (bus.flags !== 4'(f)) begin
                $display("FAIL sweep_setflags: got %b want %b", bus.flags, 4'(f)); n_err++;
            end
            n_vec++;
            for (int cc = 0; cc < 16; cc++) begin
                vld = 1'($urandom_range(0, 3) != 0);
                rw  = 1'($urandom);
                mw  = 1'($urandom);
                apply(0, vld, {4'(cc), 28'h081_0002}, rw, mw, 4'($urandom));
                if (bus.cond_ex !== exp_cond()) begin
                    $display("FAIL sweep_cond c=%0d f=%b: got %b want %b",
                             cc, 4'(f), bus.cond_ex, exp_cond());
                    n_err++;
                end
                n_vec++;
                if (bus.RegWriteG !== (rw && vld && exp_cond()) ||
                    bus.MemWriteG !== (mw && vld && exp_cond())) begin
                    $display("FAIL sweep_gate c=%0d: got %b%b want %b%b", cc, bus.RegWriteG,
                             bus.MemWriteG, rw && vld && exp_cond(), mw && vld && exp_cond());
                    n_err++;
                end
                n_vec++;
                clk_cycle();
            end
            if (bus.exec_count !== CW'(m_exec) || bus.skip_count !== CW'(m_skip)) begin
                $display("FAIL sweep_counts: got %0d/%0d want %0d/%0d",
                         bus.exec_count, bus.skip_count, m_exec, m_skip);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_ldr_str();
        apply(0, 1, 32'hE150_0001, 0, 0, 4'b0100);
        clk_cycle();
        apply(0, 1, 32'h1581_0000, 0, 1, 4'b1011);
        if (bus.MemWriteG !== 1'b0 || bus.cond_ex !== 1'b0) begin
            $display("FAIL strne_gate: got mwg %b cond %b want 0 0", bus.MemWriteG, bus.cond_ex);
            n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.flags !== 4'b0100) begin
            $display("FAIL strne_flags: got %b want 0100", bus.flags); n_err++;
        end
        n_vec++;
        apply(0, 1, 32'hE591_0000, 1, 0, 4'b1111);
        if (bus.RegWriteG !== 1'b1) begin
            $display("FAIL ldr_rwg: got %b want 1", bus.RegWriteG); n_err++;
        end
        n_vec++;
        clk_cycle();
        apply(0, 1, 32'hE550_0000, 1, 0, 4'b1011);
        clk_cycle();
        if (bus.flags !== 4'b0100) begin
            $display("FAIL ldr_flags: got %b want 0100", bus.flags); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_no_update();
        apply(0, 1, 32'hE150_0001, 0, 0, 4'b0000);
        clk_cycle();
        apply(0, 1, 32'h0150_0001, 0, 0, 4'b1111);
        if (bus.cond_ex !== 1'b0) begin
            $display("FAIL failcmp_cond: got %b want 0", bus.cond_ex); n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.flags !== 4'b0000 || bus.skip_count !== CW'(m_skip)) begin
            $display("FAIL failcmp_state: got flags %b skip %0d want 0000 %0d",
                     bus.flags, bus.skip_count, m_skip);
            n_err++;
        end
        n_vec++;
        apply(0, 0, 32'hE150_0001, 1, 1, 4'b1111);
        if (bus.RegWriteG !== 1'b0 || bus.MemWriteG !== 1'b0) begin
            $display("FAIL bubble_gate: got %b%b want 00", bus.RegWriteG, bus.MemWriteG);
            n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.flags !== 4'b0000 || bus.exec_count !== CW'(m_exec) ||
            bus.skip_count !== CW'(m_skip)) begin
            $display("FAIL bubble_state: got %b %0d/%0d want 0000 %0d/%0d",
                     bus.flags, bus.exec_count, bus.skip_count, m_exec, m_skip);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_saturation();
        apply(1, 0, 32'h0, 0, 0, 4'h0);
        clk_cycle();
        for (int i = 0; i < 17; i++) begin
            apply(0, 1, 32'hE081_0002, 1, 0, 4'($urandom));
            clk_cycle();
            if (bus.exec_count !== CW'(m_exec)) begin
                $display("FAIL sat_exec i=%0d: got %0d want %0d", i, bus.exec_count, m_exec);
                n_err++;
            end
            n_vec++;
        end
        if (bus.exec_count !== CW'(CMAX)) begin
            $display("FAIL sat_exec_final: got %0d want %0d", bus.exec_count, CMAX); n_err++;
        end
        n_vec++;
        for (int i = 0; i < 17; i++) begin
            apply(0, 1, 32'hF081_0002, 0, 0, 4'h0);
            clk_cycle();
        end
        if (bus.skip_count !== CW'(CMAX) || bus.exec_count !== CW'(CMAX)) begin
            $display("FAIL sat_skip_final: got %0d/%0d want %0d/%0d",
                     bus.exec_count, bus.skip_count, CMAX, CMAX);
            n_err++;
        end
        n_vec++;
        apply(1, 1, 32'hE150_0001, 1, 1, 4'b1111);
        if (bus.cond_ex !== 1'b0 || bus.RegWriteG !== 1'b0 || bus.MemWriteG !== 1'b0) begin
            $display("FAIL midreset_gate: got %b%b%b want 000",
                     bus.cond_ex, bus.RegWriteG, bus.MemWriteG);
            n_err++;
        end
        n_vec++;
        clk_cycle();
        if (bus.exec_count !== '0 || bus.skip_count !== '0 || bus.flags !== 4'b0000) begin
            $display("FAIL midreset_state: got %0d/%0d flags %b want 0/0 0000",
                     bus.exec_count, bus.skip_count, bus.flags);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] in;
        bit          vld;
        bit          rw;
        bit          mw;
        bit          r;
        for (int i = 0; i < 300; i++) begin
            in = $urandom;
            if ($urandom_range(0, 2) != 0) in[27:26] = 2'b00;
            if ($urandom_range(0, 3) == 0) in[31:28] = 4'hE;
            vld = 1'($urandom_range(0, 4) != 0);
            rw  = 1'($urandom);
            mw  = 1'($urandom);
            r   = 1'($urandom_range(0, 40) == 0);
            apply(r, vld, in, rw, mw, 4'($urandom));
            if (bus.cond_ex !== exp_cond() || bus.RegWriteG !== (rw && vld && exp_cond()) ||
                bus.MemWriteG !== (mw && vld && exp_cond())) begin
                $display("FAIL b2b_comb i=%0d: got %b%b%b want %b%b%b", i, bus.cond_ex,
                         bus.RegWriteG, bus.MemWriteG, exp_cond(),
                         rw && vld && exp_cond(), mw && vld && exp_cond());
                n_err++;
            end
            n_vec++;
            clk_cycle();
            if (bus.flags !== m_flags || bus.exec_count !== CW'(m_exec) ||
                bus.skip_count !== CW'(m_skip)) begin
                $display("FAIL b2b_state i=%0d: got %b %0d/%0d want %b %0d/%0d", i, bus.flags,
                         bus.exec_count, bus.skip_count, m_flags, m_exec, m_skip);
                n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        m_flags = 4'b0000;
        m_exec  = 0;
        m_skip  = 0;
        apply(1, 0, 32'h0, 0, 0, 4'h0);
        @(negedge clk);
        #1;
        test_reset();
        test_cmp_then_cond();
        test_cond_sweep();
        test_ldr_str();
        test_no_update();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
